modbus_rtu_tx_seq: RTL and testbench

Frame-level transmit sequencer for the Modbus RTU slave. It fetches an N-byte response PDU from an external byte buffer and drives the uart_byte_tx handshake one byte at a time. It computes CRC-16/Modbus on the fly and appends it low byte first. It then enforces the 3.5-character inter-frame silence before accepting the next frame. It sits between the response builder and uart_byte_tx.

---
 rtl/modbus_rtu_tx_seq_if.sv | 36 +++
 rtl/modbus_rtu_tx_seq.sv | 147 ++++++++++++++
 tb/tb_modbus_rtu_tx_seq.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/modbus_rtu_tx_seq_if.sv
// Signal bundle between the Modbus RTU transmit sequencer and its neighbours:
// the response builder (frame request), the response byte buffer (read port)
// and uart_byte_tx (byte handshake).
//
// Handshake rules:
//   frame_start/frame_len : one-cycle request, taken only while busy=0;
//                           frame_len is sampled in the same cycle.
//   buf_rd_en/buf_rd_addr : one-cycle read strobe; buf_rd_data must be valid
//                           exactly one cycle later.
//   tx_start/tx_data      : one-cycle start pulse; tx_data stays stable until
//                           uart_byte_tx answers with a one-cycle tx_done.
interface modbus_rtu_tx_seq_if;
  logic       frame_start;
  logic [7:0] frame_len;
  logic       busy;
  logic       frame_done;
  logic       err_len;
  logic       buf_rd_en;
  logic [7:0] buf_rd_addr;
  logic [7:0] buf_rd_data;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;

  // Sequencer side.
  modport slave (
    input  frame_start, frame_len, buf_rd_data, tx_done,
    output busy, frame_done, err_len, buf_rd_en, buf_rd_addr, tx_start, tx_data
  );

  // Environment side (requester, buffer, UART).
  modport master (
    output frame_start, frame_len, buf_rd_data, tx_done,
    input  busy, frame_done, err_len, buf_rd_en, buf_rd_addr, tx_start, tx_data
  );
endinterface

// File: rtl/modbus_rtu_tx_seq.sv
// Modbus RTU frame transmit sequencer: streams an N-byte PDU from the byte
// buffer into uart_byte_tx, appends CRC-16/Modbus (low byte first) and then
// holds busy for the 3.5-character inter-frame silence.
module modbus_rtu_tx_seq #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200
) (
  input  logic                      sys_clk,
  input  logic                      reset_n,
  modbus_rtu_tx_seq_if.slave        bus,
  output logic [2:0]                dbg_state
);

  // Above 19200 baud Modbus fixes the silence at 1.75 ms; below it is
  // 3.5 characters of 11 bits = 38.5 bit times. 64-bit math avoids overflow.
  localparam longint T35_L = (BAUD_RATE > 19200) ?
    (longint'(CLK_FREQ) * 64'sd1750) / 64'sd1000000 :
    (longint'(CLK_FREQ) * 64'sd77) / (64'sd2 * longint'(BAUD_RATE));
  localparam int T35   = int'(T35_L);
  localparam int CNT_W = (T35 > 1) ? $clog2(T35) : 1;
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(T35 - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    LOAD      = 3'd2,
    WAIT_DONE = 3'd3,
    CRC_LO    = 3'd4,
    CRC_HI    = 3'd5,
    GAP       = 3'd6
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       len_q;
  logic [7:0]       idx_q;
  logic [15:0]      crc_q;
  logic [CNT_W-1:0] gap_cnt;
  logic             len_ok;
  logic             last_byte;

  // One full byte of CRC-16/Modbus (reflected poly 0xA001) in a single cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  assign len_ok    = (bus.frame_len != 8'd0) && (bus.frame_len != 8'hFF);
  assign last_byte = (idx_q == (len_q - 8'd1));
  // Reset lands in GAP, so busy is already high coming out of reset.
  assign bus.busy  = (state != IDLE);
  assign dbg_state = state;

  // State register; reset enters GAP so a full silence follows every reset.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state <= GAP;
    else          state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (bus.frame_start && len_ok) state_nx = FETCH;
      FETCH:     state_nx = LOAD;
      LOAD:      state_nx = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done) state_nx = last_byte ? CRC_LO : FETCH;
      CRC_LO:    if (bus.tx_done) state_nx = CRC_HI;
      CRC_HI:    if (bus.tx_done) state_nx = GAP;
      GAP:       if (gap_cnt == GAP_LAST) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Datapath and registered outputs; every strobe defaults low so pulses
  // last exactly one cycle.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= 8'h00;
      bus.buf_rd_en   <= 1'b0;
      bus.buf_rd_addr <= 8'h00;
      bus.frame_done  <= 1'b0;
      bus.err_len     <= 1'b0;
      crc_q           <= 16'hFFFF;
      len_q           <= 8'h00;
      idx_q           <= 8'h00;
      gap_cnt         <= '0;
    end else begin
      bus.tx_start   <= 1'b0;
      bus.buf_rd_en  <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.err_len    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.frame_start) begin
            if (len_ok) begin
              len_q           <= bus.frame_len;
              crc_q           <= 16'hFFFF;
              idx_q           <= 8'h00;
              bus.buf_rd_en   <= 1'b1;
              bus.buf_rd_addr <= 8'h00;
            end else begin
              bus.err_len <= 1'b1;
            end
          end
        end
        FETCH: ;
        LOAD: begin
          bus.tx_data  <= bus.buf_rd_data;
          bus.tx_start <= 1'b1;
          crc_q        <= crc16_byte(crc_q, bus.buf_rd_data);
        end
        WAIT_DONE: begin
          if (bus.tx_done) begin
            if (last_byte) begin
              bus.tx_data  <= crc_q[7:0];
              bus.tx_start <= 1'b1;
            end else begin
              idx_q           <= idx_q + 8'd1;
              bus.buf_rd_en   <= 1'b1;
              bus.buf_rd_addr <= idx_q + 8'd1;
            end
          end
        end
        CRC_LO: begin
          if (bus.tx_done) begin
            bus.tx_data  <= crc_q[15:8];
            bus.tx_start <= 1'b1;
          end
        end
        CRC_HI: begin
          if (bus.tx_done) begin
            bus.frame_done <= 1'b1;
            gap_cnt        <= '0;
          end
        end
        GAP:     gap_cnt <= gap_cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_modbus_rtu_tx_seq.sv
// Self-checking bench for modbus_rtu_tx_seq: a byte-buffer model, a UART
// responder with random byte times, a table-driven CRC reference model and
// an expected-byte queue compared against every byte the UART accepts.
module tb_modbus_rtu_tx_seq;

  localparam int CLK_FREQ  = 1000000;
  localparam int BAUD_RATE = 115200;
  localparam int T35       = CLK_FREQ * 1750 / 1000000;  // 1750 cycles

  // ---------------- clock / reset ----------------
  logic       sys_clk;
  logic       reset_n;
  logic [2:0] dbg_state;

  modbus_rtu_tx_seq_if bus ();

  modbus_rtu_tx_seq #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .sys_clk   (sys_clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]  exp_q[$];
  logic [7:0]  mem [256];
  logic [15:0] crc_tab [256];
  int total = 0;
  int bad   = 0;
  int cyc = 0, last_done_cyc = 0;
  int tx_start_cnt = 0, frame_done_cnt = 0, err_cnt = 0, line_cnt = 0;
  int cur_len = 0, frame_byte = 0;
  int base_start = 0, base_done = 0, base_err = 0, base_line = 0;
  bit uart_busy = 0;
  int uart_left = 0;
  logic [7:0] held = 8'h00;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // CRC-16/Modbus reference: byte-wise table lookup.
  function automatic logic [15:0] model_crc(input int len);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = 0; i < len; i++) c = (c >> 8) ^ crc_tab[c[7:0] ^ mem[i]];
    return c;
  endfunction

  // Byte buffer: registered read, data one cycle after the strobe.
  always @(posedge sys_clk) begin
    if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_addr];
  end

  // UART responder and monitor, all sampling on the falling edge.
  initial begin
    bus.tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      cyc++;
      bus.tx_done = 1'b0;
      if (!reset_n) begin
        uart_busy = 0;
      end else begin
        if (bus.frame_done) frame_done_cnt++;
        if (bus.err_len)    err_cnt++;
        if (bus.buf_rd_en)  check_val("rd_addr", 32'(bus.buf_rd_addr), 32'(frame_byte));
        if (bus.tx_start) begin
          check_val("start_while_uart_busy", 32'(uart_busy), 32'd0);
          if (frame_byte >= 1 && frame_byte < cur_len)
            check_val("done_to_start", 32'(cyc - last_done_cyc), 32'd3);
          frame_byte++;
          tx_start_cnt++;
          uart_busy = 1;
          uart_left = $urandom_range(3, 12);
          held      = bus.tx_data;
        end else if (uart_busy) begin
          uart_left--;
          if (uart_left == 0) begin
            bus.tx_done   = 1'b1;
            uart_busy     = 0;
            last_done_cyc = cyc;
            line_cnt++;
            check_val("tx_hold", 32'(bus.tx_data), 32'(held));
            check_val("line_byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_val("line_byte", 32'(bus.tx_data), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic measure_busy(input int poke_a, input int poke_b, output int n);
    n = 0;
    while (bus.busy && n < 4 * T35) begin
      n++;
      bus.frame_start = (n == poke_a) || (n == poke_b);
      bus.frame_len   = 8'd4;
      @(negedge sys_clk); #1;
    end
    bus.frame_start = 1'b0;
  endtask

  task automatic start_frame(input int len, input logic [15:0] crc_want);
    for (int i = 0; i < len; i++) exp_q.push_back(mem[i]);
    exp_q.push_back(crc_want[7:0]);
    exp_q.push_back(crc_want[15:8]);
    cur_len    = len;
    frame_byte = 0;
    base_start = tx_start_cnt;
    base_done  = frame_done_cnt;
    base_err   = err_cnt;
    base_line  = line_cnt;
    @(negedge sys_clk); #1;
    bus.frame_start = 1'b1;
    bus.frame_len   = len[7:0];
    @(negedge sys_clk); #1;
    bus.frame_start = 1'b0;
  endtask

  task automatic finish_frame(input int poke_a, input int poke_b);
    int n;
    int g;
    n = 0;
    while (!bus.frame_done && n < 20000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    check_val("frame_done_seen", 32'(bus.frame_done), 32'd1);
    measure_busy(poke_a, poke_b, g);
    check_val("gap_cycles", 32'(g), 32'(T35));
    check_val("tx_start_count", 32'(tx_start_cnt - base_start), 32'(cur_len + 2));
    check_val("frame_done_count", 32'(frame_done_cnt - base_done), 32'd1);
    check_val("err_len_count", 32'(err_cnt - base_err), 32'd0);
    check_val("exp_q_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i < len; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int g;
    int n;
    int len;
    bus.frame_start = 1'b0;
    bus.frame_len   = 8'd0;
    for (int i = 0; i < 256; i++) begin
      logic [15:0] r;
      r = 16'(i);
      for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      crc_tab[i] = r;
      mem[i]     = 8'h00;
    end

    // Reset values.
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    #1;
    check_val("rst_tx_start",  32'(bus.tx_start),    32'd0);
    check_val("rst_tx_data",   32'(bus.tx_data),     32'd0);
    check_val("rst_rd_en",     32'(bus.buf_rd_en),   32'd0);
    check_val("rst_rd_addr",   32'(bus.buf_rd_addr), 32'd0);
    check_val("rst_frame_done",32'(bus.frame_done),  32'd0);
    check_val("rst_err_len",   32'(bus.err_len),     32'd0);
    check_val("rst_busy",      32'(bus.busy),        32'd1);
    check_val("rst_dbg_known", 32'($isunknown(dbg_state)), 32'd0);

    // Post-reset silence, with a request at cycle 10 that must be ignored.
    @(negedge sys_clk);
    reset_n = 1'b1;
    measure_busy(10, 0, g);
    check_val("post_reset_gap", 32'(g), 32'(T35));
    check_val("post_reset_no_tx", 32'(tx_start_cnt), 32'd0);
    check_val("post_reset_no_err", 32'(err_cnt), 32'd0);

    // Standard read reply: 01 03 00 00 00 01 -> CRC bytes 84 0A.
    mem[0] = 8'h01; mem[1] = 8'h03; mem[2] = 8'h00;
    mem[3] = 8'h00; mem[4] = 8'h00; mem[5] = 8'h01;
    start_frame(6, 16'h0A84);
    finish_frame(0, 0);

    // Bad lengths 0 and 255.
    base_start = tx_start_cnt;
    base_err   = err_cnt;
    for (int k = 0; k < 2; k++) begin
      @(negedge sys_clk); #1;
      bus.frame_start = 1'b1;
      bus.frame_len   = (k == 0) ? 8'd0 : 8'd255;
      @(negedge sys_clk); #1;
      bus.frame_start = 1'b0;
      repeat (4) @(negedge sys_clk);
      #1;
      check_val("err_len_pulse", 32'(err_cnt - base_err), 32'(k + 1));
      check_val("bad_len_busy", 32'(bus.busy), 32'd0);
    end
    check_val("bad_len_no_tx", 32'(tx_start_cnt - base_start), 32'd0);

    // Busy rejection: request during byte 2, at frame_done, and mid-gap.
    fill_random(6);
    start_frame(6, model_crc(6));
    n = 0;
    while ((tx_start_cnt - base_start) < 2 && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    bus.frame_start = 1'b1;
    bus.frame_len   = 8'd4;
    @(negedge sys_clk); #1;
    bus.frame_start = 1'b0;
    finish_frame(1, 500);

    // Reset abort during the CRC low byte.
    fill_random(6);
    start_frame(6, model_crc(6));
    n = 0;
    while ((tx_start_cnt - base_start) < 7 && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    #2 reset_n = 1'b0;
    #1;
    check_val("abort_tx_start",   32'(bus.tx_start),   32'd0);
    check_val("abort_frame_done", 32'(bus.frame_done), 32'd0);
    check_val("abort_busy",       32'(bus.busy),       32'd1);
    check_val("abort_tx_data",    32'(bus.tx_data),    32'd0);
    check_val("abort_bytes_sent", 32'(line_cnt - base_line), 32'd6);
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    measure_busy(0, 0, g);
    check_val("abort_gap", 32'(g), 32'(T35));
    check_val("abort_no_frame_done", 32'(frame_done_cnt - base_done), 32'd0);

    mem[0] = 8'hC2; mem[1] = 8'hB3; mem[2] = 8'hA4; mem[3] = 8'h95;
    start_frame(4, model_crc(4));
    finish_frame(0, 0);

    // Random frames, including the shortest and longest legal lengths.
    for (int k = 0; k < 5; k++) begin
      len = (k == 0) ? 1 : (k == 1) ? 254 : $urandom_range(2, 40);
      fill_random(len);
      start_frame(len, model_crc(len));
      finish_frame(0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
